// File: rtl/heq_sequencer.sv
// Frame sequencer for the histogram-equalisation pipeline: clears the scratchpad,
// then walks the HIST, CDF and MAP stages, with per-phase timeout and request queueing.
module heq_sequencer #(
    parameter int          NUM_BINS      = 256,
    parameter logic [23:0] PHASE_TIMEOUT = 24'd2500000
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         frame_start,
    input  logic         hist_done,
    input  logic         cdf_done,
    input  logic         map_done,
    input  logic         clear_err,
    output logic         hist_start,
    output logic         cdf_start,
    output logic         map_start,
    output logic         input_base_offset,
    output logic [1:0]   m2_owner,
    output logic         m2WE,
    output logic [15:0]  m2WriteAddr,
    output logic [127:0] m2WriteBus,
    output logic         busy,
    output logic         frame_done,
    output logic         overflow,
    output logic         err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_HIST,
        S_CDF,
        S_MAP,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [15:0] LAST_ADDR    = 16'(NUM_BINS - 1);
    localparam logic [23:0] TIMEOUT_LAST = PHASE_TIMEOUT - 24'd1;

    state_t       state_q, state_d;
    logic         pending_q, pending_d;
    logic         overflow_q, overflow_d;
    logic         ibo_q, ibo_d;
    logic [15:0]  addr_q, addr_d;
    logic [23:0]  phase_q, phase_d;
    logic         timeout;

    logic         hist_start_q, hist_start_d;
    logic         cdf_start_q, cdf_start_d;
    logic         map_start_q, map_start_d;
    logic [1:0]   owner_q, owner_d;
    logic         we_q, we_d;
    logic         busy_q, busy_d;
    logic         frame_done_q, frame_done_d;
    logic         err_q, err_d;

    // The phase counter holds the number of cycles already spent in the current phase,
    // so the last permitted cycle is the one where it equals PHASE_TIMEOUT-1.
    assign timeout = (phase_q == TIMEOUT_LAST);

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        ibo_d      = ibo_q;
        addr_d     = addr_q;
        phase_d    = phase_q;

        if (frame_start) begin
            if (pending_q || state_q == S_ERROR) begin
                overflow_d = 1'b1;
            end else if (state_q != S_IDLE) begin
                pending_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (frame_start || pending_q) begin
                    state_d   = S_CLEAR;
                    pending_d = 1'b0;
                    addr_d    = '0;
                end
            end
            S_CLEAR: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_HIST;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 16'd1;
                end
            end
            S_HIST: begin
                if (hist_done) begin
                    state_d = S_CDF;
                end else if (timeout) begin
                    state_d = S_ERROR;
                end
            end
            S_CDF: begin
                if (cdf_done) begin
                    state_d = S_MAP;
                end else if (timeout) begin
                    state_d = S_ERROR;
                end
            end
            S_MAP: begin
                if (map_done) begin
                    state_d = S_DONE;
                    ibo_d   = ~ibo_q;
                end else if (timeout) begin
                    state_d = S_ERROR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERROR: begin
                if (clear_err) begin
                    state_d    = S_IDLE;
                    overflow_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A timed-out frame abandons any queued request as well.
        if (state_d == S_ERROR && state_q != S_ERROR) begin
            pending_d = 1'b0;
        end

        if (state_d != state_q) begin
            phase_d = '0;
        end else if (state_q == S_HIST || state_q == S_CDF || state_q == S_MAP) begin
            phase_d = phase_q + 24'd1;
        end
    end

    // Outputs are decoded from the next state so their flops line up with state_q.
    always_comb begin
        hist_start_d = (state_d == S_HIST);
        cdf_start_d  = (state_d == S_CDF);
        map_start_d  = (state_d == S_MAP);
        we_d         = (state_d == S_CLEAR);
        frame_done_d = (state_d == S_DONE);
        err_d        = (state_d == S_ERROR);
        busy_d       = !(state_d == S_IDLE || state_d == S_ERROR);
        owner_d      = 2'd0;
        case (state_d)
            S_HIST:  owner_d = 2'd1;
            S_CDF:   owner_d = 2'd2;
            S_MAP:   owner_d = 2'd3;
            default: owner_d = 2'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pending_q    <= 1'b0;
            overflow_q   <= 1'b0;
            ibo_q        <= 1'b0;
            addr_q       <= '0;
            phase_q      <= '0;
            hist_start_q <= 1'b0;
            cdf_start_q  <= 1'b0;
            map_start_q  <= 1'b0;
            owner_q      <= 2'd0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
            ibo_q        <= ibo_d;
            addr_q       <= addr_d;
            phase_q      <= phase_d;
            hist_start_q <= hist_start_d;
            cdf_start_q  <= cdf_start_d;
            map_start_q  <= map_start_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign hist_start        = hist_start_q;
    assign cdf_start         = cdf_start_q;
    assign map_start         = map_start_q;
    assign input_base_offset = ibo_q;
    assign m2_owner          = owner_q;
    assign m2WE              = we_q;
    assign m2WriteAddr       = addr_q;
    assign m2WriteBus        = '0;
    assign busy              = busy_q;
    assign frame_done        = frame_done_q;
    assign overflow          = overflow_q;
    assign err               = err_q;

endmodule

// File: tb/tb_heq_sequencer.sv
// Directed, table-driven bench for heq_sequencer: each vector holds inputs for a run
// of cycles and the expected phase, overflow and buffer-select seen after every edge.
module tb_heq_sequencer;

    localparam int          NB = 256;
    localparam logic [23:0] TO = 24'd100;

    // {frame_start, hist_done, cdf_done, map_done, clear_err, rst_n}
    localparam logic [5:0] IN_IDLE = 6'b000001;
    localparam logic [5:0] IN_FS   = 6'b100001;
    localparam logic [5:0] IN_HD   = 6'b010001;
    localparam logic [5:0] IN_CD   = 6'b001001;
    localparam logic [5:0] IN_MD   = 6'b000101;
    localparam logic [5:0] IN_CE   = 6'b000011;
    localparam logic [5:0] IN_RST  = 6'b000000;

    logic         clock = 1'b0;
    logic         rst_n = 1'b0;
    logic         frame_start = 1'b0;
    logic         hist_done = 1'b0;
    logic         cdf_done = 1'b0;
    logic         map_done = 1'b0;
    logic         clear_err = 1'b0;
    logic         hist_start, cdf_start, map_start, input_base_offset;
    logic [1:0]   m2_owner;
    logic         m2WE;
    logic [15:0]  m2WriteAddr;
    logic [127:0] m2WriteBus;
    logic         busy, frame_done, overflow, err;

    always #5 clock = ~clock;

    heq_sequencer #(.NUM_BINS(NB), .PHASE_TIMEOUT(TO)) dut (
        .clock(clock), .rst_n(rst_n), .frame_start(frame_start),
        .hist_done(hist_done), .cdf_done(cdf_done), .map_done(map_done),
        .clear_err(clear_err), .hist_start(hist_start), .cdf_start(cdf_start),
        .map_start(map_start), .input_base_offset(input_base_offset),
        .m2_owner(m2_owner), .m2WE(m2WE), .m2WriteAddr(m2WriteAddr),
        .m2WriteBus(m2WriteBus), .busy(busy), .frame_done(frame_done),
        .overflow(overflow), .err(err)
    );

    typedef enum int {E_I, E_C, E_H, E_CD, E_M, E_DN, E_E} est_t;

    typedef struct {
        string      name;
        logic [5:0] in;
        int         reps;
        est_t       st;
        logic       ovf;
        logic       ibo;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   clr_idx = 0;

    // Expected {starts[3], owner[2], we, busy, frame_done, overflow, err, ibo}.
    function automatic logic [10:0] exp_obs(est_t st, logic ovf, logic ibo);
        logic [2:0] s  = 3'b000;
        logic [1:0] o  = 2'd0;
        logic       we = 1'b0;
        logic       b  = 1'b0;
        logic       fd = 1'b0;
        logic       e  = 1'b0;
        case (st)
            E_C:  begin we = 1'b1; b = 1'b1; end
            E_H:  begin s = 3'b100; o = 2'd1; b = 1'b1; end
            E_CD: begin s = 3'b010; o = 2'd2; b = 1'b1; end
            E_M:  begin s = 3'b001; o = 2'd3; b = 1'b1; end
            E_DN: begin b = 1'b1; fd = 1'b1; end
            E_E:  e = 1'b1;
            default: ;
        endcase
        return {s, o, we, b, fd, ovf, e, ibo};
    endfunction

    function automatic logic [10:0] act_obs();
        return {hist_start, cdf_start, map_start, m2_owner, m2WE, busy,
                frame_done, overflow, err, input_base_offset};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, then run the always-on checks.
    task automatic tick(input logic [5:0] in);
        {frame_start, hist_done, cdf_done, map_done, clear_err, rst_n} = in;
        @(posedge clock);
        #1;
        check("one_start", 128'($countones({hist_start, cdf_start, map_start}) <= 1), 128'd1);
        check("wbus_zero", m2WriteBus, 128'd0);
        if (m2WE === 1'b1) begin
            check("clr_addr", 128'(m2WriteAddr), 128'(clr_idx));
            clr_idx++;
        end else if (clr_idx != 0) begin
            check("clr_count", 128'(clr_idx), 128'(NB));
            clr_idx = 0;
        end
    endtask

    task automatic add(input string n, input logic [5:0] in, input int reps,
                       input est_t st, input logic ovf, input logic ibo);
        vec_t v;
        v.name = n; v.in = in; v.reps = reps; v.st = st; v.ovf = ovf; v.ibo = ibo;
        vecs.push_back(v);
    endtask

    task automatic add_clear_to_hist(input string n, input logic ovf, input logic ibo);
        add({n, "_start"}, IN_FS, 1, E_C, ovf, ibo);
        add({n, "_clear"}, IN_IDLE, NB - 1, E_C, ovf, ibo);
        add({n, "_hist"}, IN_IDLE, 1, E_H, ovf, ibo);
    endtask

    initial begin
        int cnt;
        bit found;

        add("reset", IN_RST, 2, E_I, 0, 0);
        add("idle", IN_IDLE, 3, E_I, 0, 0);
        add("hd_in_idle", IN_HD, 1, E_I, 0, 0);
        add("ce_in_idle", IN_CE, 1, E_I, 0, 0);

        add_clear_to_hist("f1", 0, 0);
        add("f1_hist_wait", IN_IDLE, 9, E_H, 0, 0);
        add("f1_hd", IN_HD, 1, E_CD, 0, 0);
        add("f1_cdf_wait", IN_IDLE, 4, E_CD, 0, 0);
        add("f1_cd", IN_CD, 1, E_M, 0, 0);
        add("f1_map_wait", IN_IDLE, 6, E_M, 0, 0);
        add("f1_md", IN_MD, 1, E_DN, 0, 1);
        add("f1_idle", IN_IDLE, 2, E_I, 0, 1);

        add("f2_start", IN_FS, 1, E_C, 0, 1);
        add("f2_cd_in_clear", IN_CD, 1, E_C, 0, 1);
        add("f2_md_in_clear", IN_MD, 1, E_C, 0, 1);
        add("f2_hd_in_clear", IN_HD, 1, E_C, 0, 1);
        add("f2_clear", IN_IDLE, NB - 4, E_C, 0, 1);
        add("f2_hist", IN_IDLE, 1, E_H, 0, 1);
        add("f2_cd_in_hist", IN_CD, 1, E_H, 0, 1);
        add("f2_md_in_hist", IN_MD, 1, E_H, 0, 1);
        add("f2_hd", IN_HD, 1, E_CD, 0, 1);
        add("f2_md_in_cdf", IN_MD, 1, E_CD, 0, 1);
        add("f2_hd_in_cdf", IN_HD, 1, E_CD, 0, 1);
        add("f2_cd", IN_CD, 1, E_M, 0, 1);
        add("f2_cd_in_map", IN_CD, 1, E_M, 0, 1);
        add("f2_md", IN_MD, 1, E_DN, 0, 0);
        add("f2_idle", IN_IDLE, 1, E_I, 0, 0);

        add_clear_to_hist("f3", 0, 0);
        add("f3_fs_in_hist", IN_FS, 1, E_H, 0, 0);
        add("f3_hd", IN_HD, 1, E_CD, 0, 0);
        add("f3_fs_in_cdf", IN_FS, 1, E_CD, 1, 0);
        add("f3_cd", IN_CD, 1, E_M, 1, 0);
        add("f3_md", IN_MD, 1, E_DN, 1, 1);
        add("f3_gap", IN_IDLE, 1, E_I, 1, 1);
        add("f4_clear", IN_IDLE, NB, E_C, 1, 1);
        add("f4_hist", IN_IDLE, 1, E_H, 1, 1);
        add("f4_hd", IN_HD, 1, E_CD, 1, 1);
        add("f4_cd", IN_CD, 1, E_M, 1, 1);
        add("f4_md", IN_MD, 1, E_DN, 1, 0);
        add("f4_idle", IN_IDLE, 2, E_I, 1, 0);

        add_clear_to_hist("t", 1, 0);
        add("t_hist_wait", IN_IDLE, 99, E_H, 1, 0);
        add("t_timeout", IN_IDLE, 1, E_E, 1, 0);
        add("t_err_hold", IN_IDLE, 2, E_E, 1, 0);
        add("t_fs_in_err", IN_FS, 1, E_E, 1, 0);
        add("t_hd_in_err", IN_HD, 1, E_E, 1, 0);
        add("t_clear_err", IN_CE, 1, E_I, 0, 0);
        add("t_idle", IN_IDLE, 2, E_I, 0, 0);

        add_clear_to_hist("r", 0, 0);
        add("r_hist_wait", IN_IDLE, 99, E_H, 0, 0);
        add("r_hd_at_timeout", IN_HD, 1, E_CD, 0, 0);
        add("r_cd", IN_CD, 1, E_M, 0, 0);
        add("r_md", IN_MD, 1, E_DN, 0, 1);
        add("r_fs_in_done", IN_FS, 1, E_I, 0, 1);
        add("r_pending_start", IN_IDLE, 1, E_C, 0, 1);
        add("r2_clear", IN_IDLE, NB - 1, E_C, 0, 1);
        add("r2_hist", IN_IDLE, 1, E_H, 0, 1);
        add("r2_hd", IN_HD, 1, E_CD, 0, 1);
        add("r2_cd", IN_CD, 1, E_M, 0, 1);
        add("r2_fs_in_map", IN_FS, 1, E_M, 0, 1);
        add("r2_reset_mid_map", IN_RST, 1, E_I, 0, 0);
        add("r2_post_reset", IN_IDLE, 3, E_I, 0, 0);

        foreach (vecs[i]) begin
            int bad_before;
            bad_before = n_bad;
            for (int r = 0; r < vecs[i].reps; r++) begin
                tick(vecs[i].in);
                check($sformatf("%s[%0d]", vecs[i].name, r), 128'(act_obs()),
                      128'(exp_obs(vecs[i].st, vecs[i].ovf, vecs[i].ibo)));
            end
            $display("vec %0d %s: in=%b cycles=%0d new_errors=%0d",
                     i, vecs[i].name, vecs[i].in, vecs[i].reps, n_bad - bad_before);
        end

        // CDF timeout with a request queued mid-phase: the queued request must not survive ERROR.
        tick(IN_FS);
        found = 0;
        for (int k = 0; k < 400 && !found; k++) begin
            tick(IN_IDLE);
            if (hist_start === 1'b1) found = 1;
        end
        check("cdf_to_reach_hist", 128'(found), 128'd1);
        tick(IN_HD);
        check("cdf_to_enter_cdf", 128'(cdf_start), 128'd1);
        cnt = 1;
        for (int k = 0; k < 200 && cdf_start === 1'b1; k++) begin
            tick((cnt == 1) ? IN_FS : IN_IDLE);
            if (cdf_start === 1'b1) cnt++;
        end
        check("cdf_to_phase_cycles", 128'(cnt), 128'(TO));
        check("cdf_to_err", 128'({err, busy, m2_owner, overflow}), 128'(5'b10000));
        tick(IN_CE);
        tick(IN_IDLE);
        tick(IN_IDLE);
        check("cdf_to_pending_dropped", 128'({busy, err, m2WE}), 128'd0);
        $display("seq cdf_timeout: phase_cycles=%0d", cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/heq_sequencer.md
HEQ_SEQUENCER -- requirements
Module: heq_sequencer

Interface
REQ-001 Parameter NUM_BINS, default 256: scratchpad bins cleared per frame, addresses 0..NUM_BINS-1.
REQ-002 Parameter PHASE_TIMEOUT, default 24'd2500000: maximum cycles allowed in one phase.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 frame_start  input  1  one-cycle request to process one frame.
REQ-006 hist_done  input  1  histogram (input pipeline) complete.
REQ-007 cdf_done  input  1  CDF stage complete.
REQ-008 map_done  input  1  output mapping stage complete.
REQ-009 clear_err  input  1  leave ERROR.
REQ-010 hist_start  output  1  level; high for the whole HIST phase.
REQ-011 cdf_start  output  1  level; high for the whole CDF phase.
REQ-012 map_start  output  1  level; high for the whole MAP phase.
REQ-013 input_base_offset  output  1  selects the ping-pong input buffer half.
REQ-014 m2_owner  output  2  scratchpad mux select: 0 = sequencer, 1 = hist, 2 = cdf, 3 = map.
REQ-015 m2WE  output  1  sequencer scratchpad write enable (CLEAR only).
REQ-016 m2WriteAddr  output  16  sequencer scratchpad write address.
REQ-017 m2WriteBus  output  128  sequencer write data; always zero.
REQ-018 busy  output  1  high in any state except IDLE and ERROR.
REQ-019 frame_done  output  1  one-cycle pulse at end of a frame.
REQ-020 overflow  output  1  sticky; a frame request was dropped.
REQ-021 err  output  1  high in ERROR.

Function
REQ-022 States: IDLE, CLEAR, HIST, CDF, MAP, DONE, ERROR; encoding is free.
REQ-023 IDLE -> CLEAR on the edge after frame_start=1 or pending=1; pending is cleared on that transition.
REQ-024 CLEAR: m2WE=1, m2WriteAddr steps 0..NUM_BINS-1 one per cycle, m2_owner=0; after address NUM_BINS-1 is written -> HIST.
REQ-025 HIST: hist_start=1, m2_owner=1; hist_done=1 -> CDF on the next edge, with hist_start low in that cycle.
REQ-026 CDF: cdf_start=1, m2_owner=2; cdf_done=1 -> MAP.
REQ-027 MAP: map_start=1, m2_owner=3; map_done=1 -> DONE.
REQ-028 DONE lasts one cycle: frame_done=1, input_base_offset toggles, then -> IDLE.
REQ-029 At most one start output is high in any cycle, and each is high only in its own state.
REQ-030 A done input outside its matching state is ignored.
REQ-031 frame_start while busy=1 and pending=0 sets pending.
REQ-032 frame_start while pending=1, or while in ERROR, is dropped and sets overflow.
REQ-033 frame_start in the DONE cycle sets pending.
REQ-034 Phase counter (24 bits) clears on every state change and increments each cycle in HIST, CDF or MAP.
REQ-035 Phase counter reaching PHASE_TIMEOUT -> ERROR: all starts low, m2_owner=0, pending cleared.
REQ-036 ERROR -> IDLE on clear_err=1; clear_err also clears overflow; input_base_offset is unchanged.
REQ-037 If a done input and the timeout occur in the same cycle, the done input wins.
REQ-038 All outputs are registered.

Reset
REQ-039 rst_n=0 on a clock edge forces IDLE at any point, including mid-frame.
REQ-040 Reset values: all starts 0, m2WE 0, m2WriteAddr 0, m2WriteBus 0, m2_owner 0, input_base_offset 0, busy 0, frame_done 0, overflow 0, err 0, pending 0, phase counter 0.

Verification
REQ-041 Nominal frame: frame_start; hist_done 10 cycles into HIST; cdf_done after 5 cycles; map_done after 7 cycles -> 256 CLEAR writes at addresses 0..255, each start high exactly for its phase, one frame_done, input_base_offset=1.
REQ-042 Back-to-back: second frame_start during HIST, third during CDF -> second frame runs with no IDLE gap wider than 1 cycle, overflow=1, input_base_offset=0 after both frames.
REQ-043 Timeout: PHASE_TIMEOUT=100, hist_done never asserted -> ERROR after 100 HIST cycles, err=1, hist_start=0; clear_err -> IDLE, err=0, overflow=0.
REQ-044 Spurious: cdf_done and map_done pulsed during CLEAR and HIST -> no state change.
REQ-045 Reset mid-MAP: rst_n=0 for one edge -> all outputs at reset values next cycle, input_base_offset=0.
REQ-046 Race: hist_done in the same cycle the timeout is reached -> CDF entered, err stays 0.
